// File: rtl/dlfloat16_pkg.sv
// rtl/dlfloat16_pkg.sv - DLFloat16 field widths, encodings and pack/unpack helpers
package dlfloat16_pkg;

  localparam int EXP_W   = 6;
  localparam int MAN_W   = 9;
  localparam int BIAS    = 31;
  localparam int EXP_MAX = 2 * BIAS + 1;
  localparam int GRD_W   = 3;
  localparam int SIG_W   = MAN_W + 1 + GRD_W;

  localparam logic [15:0] NAN_ENC = 16'h7FFF;
  localparam logic [14:0] MAXFIN  = 15'h7FFE;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } dlf16_t;

  function automatic dlf16_t unpack(input logic [15:0] w);
    return dlf16_t'(w);
  endfunction

  function automatic logic [15:0] pack(input dlf16_t f);
    return {f.sign, f.exp, f.man};
  endfunction

endpackage

// File: rtl/dlfloat16_lzc.sv
// rtl/dlfloat16_lzc.sv - 11-bit leading-zero counter; an all-zero input reports 11
module dlfloat16_lzc (
  input  logic [10:0] din,
  output logic [3:0]  cnt
);

  always_comb begin
    cnt = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (din[i]) cnt = 4'(10 - i);
    end
  end

endmodule

// File: rtl/dlfloat16_subtractor_pipe.sv
// rtl/dlfloat16_subtractor_pipe.sv - 3-stage elastic DLFloat16 subtractor, Out = A - B
module dlfloat16_subtractor_pipe
  import dlfloat16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Out
);

  localparam logic signed [7:0] E_MAX8 = 8'(EXP_MAX);

  logic load1, load2, load3;

  // Stage registers
  logic             s1_valid, s1_nan, s1_sign_l, s1_sign_s;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_lsig, s1_ssig;
  logic             s2_valid, s2_nan, s2_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [SIG_W:0]   s2_sum;

  assign load3    = !out_valid || out_ready;
  assign load2    = !s2_valid || load3;
  assign load1    = !s1_valid || load2;
  assign in_ready = load1;

  // S1: negate B, order by magnitude, align the smaller significand
  dlf16_t           a_u, b_u;
  logic             a_big, in_nan, l_sign, s_sign;
  logic [EXP_W-1:0] l_exp, s_exp, e_diff;
  logic [SIG_W-1:0] a_sig, b_sig, l_sig, s_sig, s_sh;

  always_comb begin
    a_u      = unpack(A);
    b_u      = unpack(B);
    b_u.sign = ~b_u.sign;
    in_nan   = (A[14:0] == NAN_ENC[14:0]) || (B[14:0] == NAN_ENC[14:0]);
    a_sig    = (a_u.exp == '0) ? '0 : {1'b1, a_u.man, {GRD_W{1'b0}}};
    b_sig    = (b_u.exp == '0) ? '0 : {1'b1, b_u.man, {GRD_W{1'b0}}};
    a_big    = {a_u.exp, a_u.man} >= {b_u.exp, b_u.man};
    l_sign   = a_big ? a_u.sign : b_u.sign;
    s_sign   = a_big ? b_u.sign : a_u.sign;
    l_exp    = a_big ? a_u.exp  : b_u.exp;
    s_exp    = a_big ? b_u.exp  : a_u.exp;
    l_sig    = a_big ? a_sig    : b_sig;
    s_sig    = a_big ? b_sig    : a_sig;
    e_diff   = l_exp - s_exp;
    s_sh     = (e_diff >= EXP_W'(SIG_W)) ? '0 : (s_sig >> e_diff);
  end

  // S2: magnitude add or subtract; larger operand always minus smaller, so no borrow
  logic [SIG_W:0] sum_c;
  assign sum_c = (s1_sign_l ^ s1_sign_s) ? ({1'b0, s1_lsig} - {1'b0, s1_ssig})
                                         : ({1'b0, s1_lsig} + {1'b0, s1_ssig});

  // S3: normalise, truncate, handle specials. Without a carry the leading one
  // can sit no lower than bit 2, so sum[12:2] covers every live case.
  logic [3:0]         lz;
  logic signed [7:0]  e_n;
  logic [MAN_W-1:0]   f_n;
  logic [15:0]        res;

  dlfloat16_lzc u_lzc (
    .din (s2_sum[SIG_W-1:2]),
    .cnt (lz)
  );

  always_comb begin
    e_n = '0;
    f_n = '0;
    res = '0;
    if (s2_sum[SIG_W]) begin
      e_n = $signed({2'b00, s2_exp}) + 8'sd1;
      f_n = s2_sum[SIG_W-1 -: MAN_W];
    end else begin
      e_n = $signed({2'b00, s2_exp}) - $signed({4'b0000, lz});
      f_n = MAN_W'((s2_sum[SIG_W-2:0] << lz) >> GRD_W);
    end
    if (s2_nan)
      res = NAN_ENC;
    else if (s2_sum == '0 || e_n <= 8'sd0)
      res = '0;
    else if (e_n > E_MAX8 || (e_n == E_MAX8 && f_n == '1))
      res = {s2_sign, MAXFIN};
    else
      res = pack(dlf16_t'({s2_sign, e_n[EXP_W-1:0], f_n}));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_nan    <= 1'b0;
      s1_sign_l <= 1'b0;
      s1_sign_s <= 1'b0;
      s1_exp    <= '0;
      s1_lsig   <= '0;
      s1_ssig   <= '0;
      s2_valid  <= 1'b0;
      s2_nan    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_exp    <= '0;
      s2_sum    <= '0;
      out_valid <= 1'b0;
      Out       <= '0;
    end else begin
      if (load1) s1_valid <= in_valid;
      if (load1 && in_valid) begin
        s1_nan    <= in_nan;
        s1_sign_l <= l_sign;
        s1_sign_s <= s_sign;
        s1_exp    <= l_exp;
        s1_lsig   <= l_sig;
        s1_ssig   <= s_sh;
      end
      if (load2) s2_valid <= s1_valid;
      if (load2 && s1_valid) begin
        s2_nan  <= s1_nan;
        s2_sign <= s1_sign_l;
        s2_exp  <= s1_exp;
        s2_sum  <= sum_c;
      end
      if (load3) out_valid <= s2_valid;
      if (load3 && s2_valid) Out <= res;
    end
  end

endmodule

// File: tb/tb_dlfloat16_subtractor_pipe.sv
// tb/tb_dlfloat16_subtractor_pipe.sv - directed checks of the pipelined DLFloat16 subtractor
module tb_dlfloat16_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, Out;

  int n_cmp = 0;
  int n_err = 0;

  dlfloat16_subtractor_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated pair: accept edge, then result visible after the third edge
  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, {15'b0, in_ready}, 16'h0001);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, {15'b0, out_valid}, 16'h0000);
    @(negedge clk);
    check({tag, "_lat2"}, {15'b0, out_valid}, 16'h0000);
    @(negedge clk);
    check({tag, "_valid"}, {15'b0, out_valid}, 16'h0001);
    check({tag, "_out"}, Out, exp);
  endtask

  logic [15:0] d_a [8] = '{16'h4000, 16'h3E00, 16'h3F00, 16'h3E00,
                           16'h3E00, 16'h7FFF, 16'h7FFE, 16'h0123};
  logic [15:0] d_b [8] = '{16'h3E00, 16'h3E00, 16'h3C00, 16'h4000,
                           16'hBE00, 16'h3E00, 16'hFFFE, 16'h0000};
  logic [15:0] d_e [8] = '{16'h3E00, 16'h0000, 16'h3E00, 16'hBE00,
                           16'h4000, 16'h7FFF, 16'h7FFE, 16'h0000};

  logic [15:0] v_a [6] = '{16'h4000, 16'h3E00, 16'h3F00, 16'h3E00, 16'h3E00, 16'h7FFF};
  logic [15:0] v_b [6] = '{16'h3E00, 16'h3E00, 16'h3C00, 16'h4000, 16'hBE00, 16'h3E00};
  logic [15:0] v_e [6] = '{16'h3E00, 16'h0000, 16'h3E00, 16'hBE00, 16'h4000, 16'h7FFF};

  initial begin
    int occ, n_sent, n_got;
    logic prev_stall;
    logic [15:0] prev_out;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {15'b0, out_valid}, 16'h0000);
    check("rst_out", Out, 16'h0000);
    check("rst_in_ready", {15'b0, in_ready}, 16'h0001);

    for (int i = 0; i < 8; i++)
      send_one($sformatf("vec%0d", i), d_a[i], d_b[i], d_e[i]);

    // Backpressure: 6 back-to-back pairs, consumer stalls cycles 2..5
    occ = 0; n_sent = 0; n_got = 0; prev_stall = 1'b0; prev_out = '0;
    for (int c = 0; c < 40 && n_got < 6; c++) begin
      @(negedge clk);
      if (prev_stall) check("bp_hold", Out, prev_out);
      out_ready = !(c >= 2 && c <= 5);
      if (n_sent < 6) begin
        A = v_a[n_sent]; B = v_b[n_sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("bp_in_ready", {15'b0, in_ready}, {15'b0, (occ < 3) || out_ready});
      if (out_valid && out_ready) begin
        check($sformatf("bp_out%0d", n_got), Out, v_e[n_got]);
        n_got++;
        occ--;
      end
      if (in_valid && in_ready) begin
        n_sent++;
        occ++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = Out;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", 16'(n_got), 16'd6);

    // Reset with two pairs in flight
    @(negedge clk);
    A = 16'h3E00; B = 16'h4000; in_valid = 1'b1;
    @(negedge clk);
    A = 16'h4000; B = 16'h3E00;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {15'b0, out_valid}, 16'h0000);
    check("mid_rst_out", Out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_drop", {15'b0, out_valid}, 16'h0000);
    end
    send_one("post_rst", 16'h3F00, 16'h3C00, 16'h3E00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
